// File: rtl/backing_ram_pkg.sv
// Shared constants and types for the backing RAM and the cache that sits in front of it.
package backing_ram_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned DEFAULT_ADDR_BITS = 8;
  localparam int unsigned DEFAULT_LATENCY   = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              wr;
  } req_t;

  // Counter must be at least one bit wide even when LATENCY == 1.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/backing_ram.sv
// Word-organised main-memory model with fixed multi-cycle latency; requests are detected by any
// change of {data, addr, wr}, and response drops combinationally as soon as the inputs change.
module backing_ram
  import backing_ram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int unsigned LATENCY   = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  output logic              response,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = cnt_width(LATENCY);

  req_t                 cur_req;
  req_t                 req_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_W-1:0]    out_q;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic                 changed;

  always_comb begin
    cur_req = '{data: data, addr: addr, wr: wr};
    changed = (cur_req != req_q);
    idx     = req_q.addr[ADDR_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      out_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (changed) begin
      // A new request always wins, silently dropping any operation still in flight.
      req_q  <= cur_req;
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(LATENCY - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
        if (req_q.wr) begin
          mem_q[idx] <= req_q.data;
          out_q      <= req_q.data;
        end else begin
          out_q <= mem_q[idx];
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign response = !busy_q && !changed;
  assign out      = out_q;

endmodule

// File: tb/tb_backing_ram.sv
// Directed self-checking bench for backing_ram: write, read-back, abort, idle, aliasing, reset.
module tb_backing_ram;
  import backing_ram_pkg::*;

  localparam int unsigned LAT = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              response;
  logic [DATA_W-1:0] out;

  int tests;
  int fails;

  backing_ram #(
    .ADDR_BITS(8),
    .LATENCY  (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .addr    (addr),
    .wr      (wr),
    .response(response),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] a, input logic w);
    data = d;
    addr = a;
    wr   = w;
  endtask

  // Present a request, confirm the same-cycle drop, LAT busy edges, then completion.
  task automatic do_req(input string tag, input logic [31:0] d, input logic [31:0] a,
                        input logic w, input logic [31:0] exp);
    drive(d, a, w);
    #1;
    check({tag, "_drop"}, {31'd0, response}, 32'd1 ^ 32'd1);
    for (int i = 0; i < LAT; i++) begin
      step();
      check({tag, "_busy"}, {31'd0, response}, 32'd0);
    end
    step();
    check({tag, "_resp"}, {31'd0, response}, 32'd1);
    check({tag, "_out"}, out, exp);
  endtask

  logic [31:0] held;

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    #1;
    check("reset_resp", {31'd0, response}, 32'd1);
    check("reset_out", out, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_reset_resp", {31'd0, response}, 32'd1);

    do_req("wr5", 32'hDEADBEEF, 32'd5, 1'b1, 32'hDEADBEEF);
    do_req("rd5", 32'hDEADBEEF, 32'd5, 1'b0, 32'hDEADBEEF);
    do_req("rd6", 32'hDEADBEEF, 32'd6, 1'b0, 32'h0);

    // Abort: write to 7 replaced by write to 8 after two edges.
    drive(32'h11, 32'd7, 1'b1);
    step();
    step();
    do_req("abort_wr8", 32'h22, 32'd8, 1'b1, 32'h22);
    do_req("rd7", 32'h22, 32'd7, 1'b0, 32'h0);
    do_req("rd8", 32'h22, 32'd8, 1'b0, 32'h22);

    // Idle: re-presenting the same read must not restart anything.
    held = out;
    for (int i = 0; i < 10; i++) begin
      drive(32'h22, 32'd8, 1'b0);
      #1;
      check("idle_resp", {31'd0, response}, 32'd1);
      step();
      check("idle_out", out, 32'h22);
    end

    do_req("wr105", 32'hA5, 32'h105, 1'b1, 32'hA5);
    do_req("rd005", 32'hA5, 32'h005, 1'b0, 32'hA5);

    // Reset mid-write: clears state and memory.
    drive(32'h77, 32'd3, 1'b1);
    step();
    step();
    #2;
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    #1;
    check("midreset_resp", {31'd0, response}, 32'd1);
    check("midreset_out", out, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("release_resp", {31'd0, response}, 32'd1);
    do_req("rd3_after_rst", 32'h0, 32'd3, 1'b0, 32'h0);
    do_req("rd5_after_rst", 32'h0, 32'd5, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/backing_ram.md
Name: backing_ram

Overview:
- Word-organised main-memory model with multi-cycle latency.
- Sits behind the 4-way cache and serves its read misses and write-through writes.
- A new request is recognised purely by a change in the presented inputs (data, addr, wr); there is no request strobe.
- `response` signals completion; `out` carries the result.

Parameters:
- ADDR_BITS, 8, number of low address bits used as word index; depth = 2**ADDR_BITS words.
- LATENCY, 4, clock cycles from request capture to completion (>= 1).
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data  input  32  write data.
- addr  input  32  word address; only addr[ADDR_BITS-1:0] is used, upper bits alias.
- wr  input  1  1 = write, 0 = read.
- response  output  1  1 = idle, last request complete, `out` valid.
- out  output  32  read data, or the written word after a write.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset state:
  - latched request {data, addr, wr} = 0
  - busy = 0, counter = 0
  - out = 0, response = 1
  - all memory words = 0
- Request detection: on each rising edge, if {data, addr, wr} differs from the latched request:
  - latch the new request
  - set busy = 1
  - load counter = LATENCY-1
- Restart: a differing request arriving while busy aborts the current operation and restarts with the new request. An aborted write is not committed.
- While busy with an unchanged request, counter decrements each edge. At the edge where busy and counter == 0:
  - write: mem[idx] <= latched data; out <= latched data
  - read: out <= mem[idx]
  - busy <= 0
- Completion timing: completion occurs exactly LATENCY edges after the capture edge.
- response is combinational: response = !busy && ({data, addr, wr} == latched request).
  - It drops in the same cycle the inputs change, before the capture edge.
  - The client therefore never sees a stale response=1 for a new request.
- Idle behaviour: inputs equal to the latched request start no operation.
  - Re-presenting a completed request keeps response = 1 and out unchanged.
- Stability: out holds its value between completions. out is undefined-free: always a registered value.
- Memory update: only at write completion, one word per write, no byte enables.
- Address mapping: idx = addr[ADDR_BITS-1:0]. Addresses differing only above ADDR_BITS alias to the same word.
- Reset mid-operation: abort, return to reset state, clear memory. The next edge after reset release treats the current inputs as a new request if they are nonzero.

Decomposition:
- Shared package: DATA_W, default ADDR_BITS, default LATENCY. Reused by the cache and this block.
- Single module; no sub-module needed.
  - The latency counter and request latch are small enough to live inline.

Test Plan:
- Write: after reset, drive addr=5, data=0xDEADBEEF, wr=1.
  - response drops the same cycle.
  - Exactly LATENCY=4 edges later response=1 and out=0xDEADBEEF.
- Read-back: then drive wr=0, addr=5.
  - response=0 for 4 edges, then 1 with out=0xDEADBEEF.
  - Read of unwritten addr=6 returns out=0.
- Abort: start write addr=7, data=0x11; change to addr=8, data=0x22 after 2 cycles.
  - Completion occurs 4 edges after the change.
  - A subsequent read of addr=7 returns 0; a read of addr=8 returns 0x22.
- Idle: hold inputs unchanged after completion for 10 cycles.
  - response stays 1 and out stable.
  - Reading the same address twice consecutively starts no new operation.
- Aliasing: write addr=0x105, data=0xA5 (ADDR_BITS=8), then read addr=0x005 -> out=0xA5.
- Reset mid-operation: assert rst asynchronously during a pending write addr=3, data=0x77.
  - response=1 and out=0 immediately.
  - After release, a read of addr=3 returns 0.
